// File: rtl/jarvis_pkg.sv
// Shared types and constants for the fetch front end.
// PC_GEN_RVC_EN selects 16-bit (compressed) instead of 32-bit target alignment.
package jarvis_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } pc_state_t;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

`ifdef PC_GEN_RVC_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFE;
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
`endif

endpackage

// File: rtl/pc_align_chk.sv
// Combinational alignment check of a control-transfer target against ALIGN_MASK.
// Alignment granularity follows PC_GEN_RVC_EN through the package mask.
module pc_align_chk
    import jarvis_pkg::*;
(
    input  logic [XLEN-1:0] target,
    output logic            aligned
);

    assign aligned = ((target & ~ALIGN_MASK) == '0);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator feeding instr_fetch: sequential +4, redirects, stall, fault.
// Build option PC_GEN_RVC_EN relaxes target alignment to 2 bytes (via jarvis_pkg).
module pc_gen
    import jarvis_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR        = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR_DEFAULT = DEFAULT_TRAP_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            trap_vector_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            misaligned,
    output logic [1:0]      state
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;
    logic            target_aligned;
    logic [XLEN-1:0] trap_target;

    pc_align_chk u_align_chk (
        .target  (branch_target),
        .aligned (target_aligned)
    );

    assign trap_target = trap_vector_valid ? (trap_vector & ALIGN_MASK) : TRAP_VECTOR_DEFAULT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (trap) begin
                    pc_d = trap_target;
                end
            end
            FAULT: begin
                // Only a trap recovers from a bad redirect; branches and stalls are ignored.
                if (trap) begin
                    pc_d    = trap_target;
                    state_d = RUN;
                end
            end
            default: begin
                if (trap) begin
                    pc_d    = trap_target;
                    state_d = RUN;
                end else if (branch_taken) begin
                    if (target_aligned) begin
                        pc_d    = branch_target;
                        state_d = RUN;
                    end else begin
                        misaligned_d = 1'b1;
                        state_d      = FAULT;
                    end
                end else if (stall) begin
                    state_d = HOLD;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    state_d = RUN;
                end
            end
        endcase
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign pc_valid   = (state_q == RUN) || (state_q == HOLD);
    assign misaligned = misaligned_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the next-PC rules.
module tb_pc_gen;
    import jarvis_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        trap = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        trap_vector_valid = 1'b0;
    logic [31:0] pc, pc_plus4;
    logic        pc_valid, misaligned;
    logic [1:0]  state;

    pc_gen dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .trap              (trap),
        .trap_vector       (trap_vector),
        .trap_vector_valid (trap_vector_valid),
        .pc                (pc),
        .pc_plus4          (pc_plus4),
        .pc_valid          (pc_valid),
        .misaligned        (misaligned),
        .state             (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: state numbers are the architectural encodings 0..3.
    logic [31:0] m_pc  = 32'h0;
    int          m_st  = 0;
    logic        m_mis = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit is_aligned(input logic [31:0] a);
`ifdef PC_GEN_RVC_EN
        return (a % 2) == 0;
`else
        return (a % 4) == 0;
`endif
    endfunction

    function automatic logic [31:0] trap_addr(input logic v, input logic [31:0] tv);
        if (!v) return 32'h0000_0100;
`ifdef PC_GEN_RVC_EN
        return tv - (tv % 2);
`else
        return tv - (tv % 4);
`endif
    endfunction

    task automatic model_edge();
        m_mis = 1'b0;
        if (m_st == 0) begin
            if (trap) m_pc = trap_addr(trap_vector_valid, trap_vector);
            m_st = 1;
        end else if (m_st == 3) begin
            if (trap) begin
                m_pc = trap_addr(trap_vector_valid, trap_vector);
                m_st = 1;
            end
        end else if (trap) begin
            m_pc = trap_addr(trap_vector_valid, trap_vector);
            m_st = 1;
        end else if (branch_taken && is_aligned(branch_target)) begin
            m_pc = branch_target;
            m_st = 1;
        end else if (branch_taken) begin
            m_mis = 1'b1;
            m_st  = 3;
        end else if (stall) begin
            m_st = 2;
        end else begin
            m_pc = m_pc + 32'd4;
            m_st = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, (m_st == 1 || m_st == 2)});
        check({tag, ".misaligned"}, {31'b0, misaligned}, {31'b0, m_mis});
        check({tag, ".state"}, {30'b0, state}, m_st[31:0]);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_all(tag);
        $display("cyc %0d %s st=%0d br=%0b tgt=%h trap=%0b -> pc=%h state=%0d valid=%0b mis=%0b",
                 cyc, tag, stall, branch_taken, branch_target, trap, pc, state, pc_valid, misaligned);
    endtask

    // Called just after a cycle's check: asserts reset mid-cycle and releases before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_pc = 32'h0; m_st = 0; m_mis = 1'b0;
        check_all(tag);
        $display("cyc %0d %s async reset -> pc=%h state=%0d", cyc, tag, pc, state);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; branch_taken = 1'b0; trap = 1'b0; trap_vector_valid = 1'b0;
    endtask

    initial begin
        #2;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Boot cycle then sequential fetch 0,4,8
        for (int i = 0; i < 3; i++) cycle("seq");
        check("seq_at8", pc, 32'h8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle("stall");
        check("stall_pc", pc, 32'h8);
        check("stall_state", {30'b0, state}, 32'd2);
        stall = 1'b0;
        cycle("unstall");
        check("unstall_pc", pc, 32'hC);
        cycle("seq");
        check("seq_10", pc, 32'h10);

        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        cycle("br_stall");
        check("br_stall_pc", pc, 32'h40);
        check("br_stall_state", {30'b0, state}, 32'd1);

        stall = 1'b0; branch_target = 32'h42;
        cycle("br_mis");
`ifndef PC_GEN_RVC_EN
        check("mis_pulse", {31'b0, misaligned}, 32'd1);
        check("mis_valid", {31'b0, pc_valid}, 32'd0);
        check("mis_pc", pc, 32'h40);
`endif
        branch_taken = 1'b0;
        cycle("fault_hold");
        check("mis_clear", {31'b0, misaligned}, 32'd0);
        trap = 1'b1; trap_vector_valid = 1'b0;
        cycle("trap_dflt");
        check("trap_dflt_pc", pc, 32'h100);

        branch_taken = 1'b1; branch_target = 32'h80; trap_vector = 32'h200; trap_vector_valid = 1'b1;
        cycle("trap_wins");
        check("trap_wins_pc", pc, 32'h200);
        trap = 1'b0; branch_target = 32'hFFFF_FFFC;
        cycle("br_top");
        idle_inputs();
        cycle("wrap");
        check("wrap_pc", pc, 32'h0);

        for (int i = 0; i < 9; i++) cycle("seq");
        check("pre_rst_pc", pc, 32'h24);
        async_reset("midrst");
        check("midrst_pc", pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 99) < 30);
            branch_taken  = ($urandom_range(0, 99) < 15);
            branch_target = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) branch_target = branch_target | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) branch_target = 32'hFFFF_FFFC;
            trap              = ($urandom_range(0, 99) < 6);
            trap_vector       = $urandom;
            trap_vector_valid = $urandom_range(0, 1) == 1;
            cycle("rand");
            if ($urandom_range(0, 79) == 0) async_reset("rand_rst");
        end

        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
